// File: rtl/registers.sv
// 32 x 32-bit general-purpose register file: two combinational read ports (A, B)
// and one clocked write port (C). Register 0 always reads as zero.
module registers #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dataa,
   input  logic [ADDR_WIDTH-1:0] addrb,
   output logic [DATA_WIDTH-1:0] datab,
   input  logic                  enc,
   input  logic [ADDR_WIDTH-1:0] addrc,
   input  logic [DATA_WIDTH-1:0] datac
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  write_hit;

   // Writes aimed at r0 are dropped here so the storage for r0 stays zero.
   assign write_hit = enc && (addrc != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_hit) begin
         regs[addrc] <= datac;
      end
   end

   // No write-to-read bypass: a read of the address being written shows the old
   // value until the clock edge commits the new one.
   always_comb begin
      dataa = '0;
      datab = '0;
      if (!reset && (addra != '0)) begin
         dataa = regs[addra];
      end
      if (!reset && (addrb != '0)) begin
         datab = regs[addrb];
      end
   end

endmodule

// File: tb/tb_registers.sv
// Scoreboard bench for the register file: directed stimulus queues expected read
// data, and a monitor samples both read ports shortly after each request.
module tb_registers;

   logic        clock;
   logic        reset;
   logic [4:0]  addra;
   logic [31:0] dataa;
   logic [4:0]  addrb;
   logic [31:0] datab;
   logic        enc;
   logic [4:0]  addrc;
   logic [31:0] datac;

   typedef struct {
      string       name;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   vectors_applied = 0;
   int   miscompares = 0;

   registers #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clock(clock),
      .reset(reset),
      .addra(addra),
      .dataa(dataa),
      .addrb(addrb),
      .datab(datab),
      .enc(enc),
      .addrc(addrc),
      .datac(datac)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: one sample per request, 1 time unit after it, well clear of posedge.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         vectors_applied++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: sample with no expected entry");
         end else begin
            e = exp_q.pop_front();
            if (dataa !== e.exp_a || datab !== e.exp_b) begin
               miscompares++;
               $display("[TB] FAIL %s: got a=%08h b=%08h, expected a=%08h b=%08h",
                        e.name, dataa, datab, e.exp_a, e.exp_b);
            end
         end
      end
   end

   // Presents read addresses and queues what both ports must show.
   task automatic check_output(input string name, input logic [4:0] aa, input logic [4:0] ab,
                               input logic [31:0] ea, input logic [31:0] eb);
      exp_t e;
      addra = aa;
      addrb = ab;
      e.name  = name;
      e.exp_a = ea;
      e.exp_b = eb;
      exp_q.push_back(e);
      -> sample_ev;
      #2;
   endtask

   // Called just after a negedge; returns just after the following negedge.
   task automatic apply_stimulus(input logic we, input logic [4:0] addr, input logic [31:0] data);
      enc   = we;
      addrc = addr;
      datac = data;
      @(posedge clock);
      @(negedge clock);
      enc = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      enc   = 1'b0;
      addrc = '0;
      datac = '0;
      addra = '0;
      addrb = '0;
      repeat (2) @(negedge clock);
      check_output("reset_hold", 5'd0, 5'd31, 32'h0, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      check_output("after_reset", 5'd5, 5'd7, 32'h0, 32'h0);

      // Asynchronous clear between edges
      @(negedge clock);
      apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF);
      check_output("r5_written", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
      reset = 1'b1;
      check_output("async_clear", 5'd5, 5'd0, 32'h0, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      check_output("r5_stays_clear", 5'd5, 5'd5, 32'h0, 32'h0);

      @(negedge clock);
      apply_stimulus(1'b1, 5'd7, 32'h12345678);
      check_output("basic_rw", 5'd7, 5'd7, 32'h12345678, 32'h12345678);

      apply_stimulus(1'b0, 5'd3, 32'hFFFFFFFF);
      check_output("enable_off", 5'd3, 5'd3, 32'h0, 32'h0);
      apply_stimulus(1'b1, 5'd3, 32'hFFFFFFFF);
      check_output("enable_on", 5'd3, 5'd7, 32'hFFFFFFFF, 32'h12345678);

      apply_stimulus(1'b1, 5'd0, 32'hAAAA5555);
      check_output("r0_zero", 5'd0, 5'd0, 32'h0, 32'h0);

      // Back-to-back writes on consecutive edges
      apply_stimulus(1'b1, 5'd1, 32'h11111111);
      apply_stimulus(1'b1, 5'd31, 32'h80000001);
      check_output("dual_port", 5'd1, 5'd31, 32'h11111111, 32'h80000001);
      check_output("dual_swap", 5'd31, 5'd1, 32'h80000001, 32'h11111111);

      // Read/write collision on r9
      apply_stimulus(1'b1, 5'd9, 32'h00000001);
      @(negedge clock);
      enc   = 1'b1;
      addrc = 5'd9;
      datac = 32'h00000002;
      check_output("collision_before", 5'd9, 5'd9, 32'h00000001, 32'h00000001);
      @(posedge clock);
      @(negedge clock);
      enc = 1'b0;
      check_output("collision_after", 5'd9, 5'd1, 32'h00000002, 32'h11111111);

      // Reset overrides a write pending in the same cycle
      @(negedge clock);
      enc   = 1'b1;
      addrc = 5'd9;
      datac = 32'h00000003;
      #2;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_output("reset_vs_write", 5'd9, 5'd31, 32'h0, 32'h0);
      enc   = 1'b0;
      reset = 1'b0;
      check_output("post_reset_clear", 5'd9, 5'd7, 32'h0, 32'h0);

      @(negedge clock);
      apply_stimulus(1'b1, 5'd9, 32'hCAFEF00D);
      check_output("write_after_reset", 5'd9, 5'd3, 32'hCAFEF00D, 32'h0);
      apply_stimulus(1'b1, 5'd30, 32'h5A5A5A5A);
      check_output("r30_neighbors", 5'd30, 5'd31, 32'h5A5A5A5A, 32'h0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(negedge clock);
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
